// File: rtl/ro_multi_capture.sv
// Multi-channel ring-oscillator edge counter. Counts over fixed gate windows and
// queues tagged per-channel counts in a FIFO that a host drains on the same clock.
//
// state    | meaning
// S_IDLE   | no session, waiting for start
// S_GATE   | counting windows; the previous window's drain may run alongside
// S_FINISH | session ending, letting the in-flight drain complete

module ro_multi_capture #(
  parameter int N_CH        = 4,
  parameter int CH_W        = 2,
  parameter int CNT_W       = 32,
  parameter int GATE_CYCLES = 1000,
  parameter int ADDR_W      = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   ro_in,
  input  logic              start,
  input  logic              stop,
  input  logic              mode,
  input  logic [N_CH-1:0]   ch_en,
  input  logic              rd_en,
  output logic [CNT_W-1:0]  rd_data,
  output logic [CH_W-1:0]   rd_ch,
  output logic              rd_valid,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              empty,
  output logic              busy,
  output logic              ovf
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int GW    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int IW    = (N_CH > 1) ? $clog2(N_CH) : 1;

  localparam logic [GW-1:0]   GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [IW-1:0]   IDX_LAST  = IW'(N_CH - 1);
  localparam logic [ADDR_W:0] LVL_FULL  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GATE,
    S_FINISH
  } state_t;

  state_t                   state;
  logic [N_CH-1:0]          ro_s1, ro_s2, ro_d;
  logic [N_CH-1:0]          ro_rise;
  logic [CNT_W-1:0]         cnt  [N_CH];
  logic [CNT_W-1:0]         snap [N_CH];
  logic [GW-1:0]            gate;
  logic [IW-1:0]            drain_idx;
  logic                     drain_act;
  logic                     drain_drop;
  logic                     mode_q;
  logic [N_CH-1:0]          en_q;
  logic [ADDR_W-1:0]        wr_ptr, rd_ptr;
  logic [CH_W+CNT_W-1:0]    mem [DEPTH];

  logic win_end, drain_last, do_rd, wr_req, wr_ok, wr_ovw, wr_drop, mem_we;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic e);
    return (e && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  assign ro_rise    = ro_s2 & ~ro_d;
  assign full       = (level == LVL_FULL);
  assign empty      = (level == '0);
  // stop on the last window cycle discards that window rather than capturing it
  assign win_end    = (state == S_GATE) && (gate == GATE_LAST) && !stop;
  assign drain_last = drain_act && (drain_idx == IDX_LAST);
  assign do_rd      = rd_en && !empty;
  assign wr_req     = drain_act && en_q[drain_idx] && !drain_drop;
  assign wr_ok      = wr_req && (!full || do_rd);
  assign wr_ovw     = wr_req && full && !do_rd && mode_q;
  assign wr_drop    = wr_req && full && !do_rd && !mode_q;
  assign mem_we     = wr_ok || wr_ovw;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ro_s1 <= '0;
      ro_s2 <= '0;
      ro_d  <= '0;
    end else begin
      ro_s1 <= ro_in;
      ro_s2 <= ro_s1;
      ro_d  <= ro_s2;
    end
  end

  // An edge seen on the last window cycle still lands in that window's snapshot.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N_CH; i++) begin
        cnt[i]  <= '0;
        snap[i] <= '0;
      end
    end else if ((state == S_IDLE) && start) begin
      for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
    end else if (state == S_GATE) begin
      for (int i = 0; i < N_CH; i++) begin
        if (gate == GATE_LAST) begin
          cnt[i]  <= '0;
          snap[i] <= sat_inc(cnt[i], ro_rise[i]);
        end else begin
          cnt[i]  <= sat_inc(cnt[i], ro_rise[i]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr] <= {CH_W'(drain_idx), snap[drain_idx]};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      ovf        <= 1'b0;
      mode_q     <= 1'b0;
      en_q       <= '0;
      gate       <= '0;
      drain_act  <= 1'b0;
      drain_idx  <= '0;
      drain_drop <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      rd_data    <= '0;
      rd_ch      <= '0;
      rd_valid   <= 1'b0;
    end else begin
      rd_valid <= do_rd;
      if (do_rd) {rd_ch, rd_data} <= mem[rd_ptr];

      if (mem_we) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd || wr_ovw) rd_ptr <= rd_ptr + 1'b1;
      if (wr_ok && !do_rd) level <= level + 1'b1;
      else if (do_rd && !wr_ok) level <= level - 1'b1;

      if (wr_ovw || wr_drop) ovf <= 1'b1;

      if (drain_act) begin
        drain_idx  <= drain_last ? '0 : drain_idx + 1'b1;
        drain_act  <= !drain_last;
        drain_drop <= drain_last ? 1'b0 : (drain_drop | wr_drop);
      end
      if (win_end) begin
        drain_act <= 1'b1;
        drain_idx <= '0;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_GATE;
            busy   <= 1'b1;
            mode_q <= mode;
            en_q   <= ch_en;
            ovf    <= 1'b0;
            gate   <= '0;
          end
        end
        S_GATE: begin
          gate <= (gate == GATE_LAST) ? '0 : gate + 1'b1;
          // a one-shot drop ends the session just like stop, after the drain
          if (stop || wr_drop) begin
            if (drain_act && !drain_last) begin
              state <= S_FINISH;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        S_FINISH: begin
          if (!drain_act || drain_last) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
